// File: rtl/load_store_unit.sv
// Memory-access stage: issues one aligned load/store to a valid/ready data port,
// then sign/zero-extends load data into a registered write-back payload.
package load_store_unit_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } write_back_t;
endpackage

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output write_back_t wb,
    output logic        busy,
    output logic        fault
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int unsigned CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_load_q, is_load_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lane_q, lane_d;
    logic             req_ready_q, req_ready_d;
    logic             mem_req_valid_q, mem_req_valid_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    write_back_t      wb_q, wb_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    logic             single_c, f3_ok_c, align_ok_c;
    logic [3:0]       strb_c;
    logic [31:0]      wdata_c, load_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;

    // Request legality and store lane placement, evaluated at the handshake
    always_comb begin
        single_c = req_is_load ^ req_is_store;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok_c = 1'b1;
            3'b100, 3'b101:         f3_ok_c = req_is_load;
            default:                f3_ok_c = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   align_ok_c = ~req_addr[0];
            2'b10:   align_ok_c = (req_addr[1:0] == 2'b00);
            default: align_ok_c = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                strb_c  = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                strb_c  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                strb_c  = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
    end

    always_comb begin
        byte_c = mem_rdata[{lane_q, 3'b000} +: 8];
        half_c = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'h0, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'h0, half_c};
            default: load_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        wb_d        = wb_q;
        fault_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q && single_c) begin
                    if (f3_ok_c && align_ok_c) begin
                        state_d     = ISSUE;
                        is_load_d   = req_is_load;
                        f3_d        = req_funct3;
                        lane_d      = req_addr[1:0];
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_we_d    = req_is_store;
                        mem_wstrb_d = req_is_store ? strb_c : 4'b0000;
                        mem_wdata_d = wdata_c;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = DONE;
                    if (is_load_q) wb_d.data = load_c;
                end else if (RSP_TIMEOUT != 0 && cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d     = (state_d == IDLE);
        busy_d          = (state_d != IDLE);
        mem_req_valid_d = (state_d == ISSUE);
        wb_d.valid      = (state_d == DONE) && is_load_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            is_load_q       <= 1'b0;
            f3_q            <= 3'b000;
            lane_q          <= 2'b00;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_we_q        <= 1'b0;
            mem_wstrb_q     <= 4'b0000;
            mem_wdata_q     <= 32'h0;
            wb_q            <= '0;
            busy_q          <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_load_q       <= is_load_d;
            f3_q            <= f3_d;
            lane_q          <= lane_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wstrb_q     <= mem_wstrb_d;
            mem_wdata_q     <= mem_wdata_d;
            wb_q            <= wb_d;
            busy_q          <= busy_d;
            fault_q         <= fault_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_wdata     = mem_wdata_q;
    assign wb            = wb_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions checked against an arithmetic model of the access rules.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_load, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    write_back_t wb;
    logic        busy, fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_wb = 32'h0;

    load_store_unit #(.RSP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb(wb), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes is 2**funct3[1:0]
    function automatic bit model_legal(bit ld, logic [2:0] f3, logic [31:0] addr);
        int size;
        bit f3_ok;
        size = 1 << f3[1:0];
        if (ld) f3_ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    f3_ok = (f3 <= 2);
        return f3_ok && ((addr % size) == 0);
    endfunction

    function automatic logic [3:0] model_strb(logic [2:0] f3, logic [31:0] addr);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wd);
        if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rd);
        logic [31:0] sh, v;
        sh = rd >> (8 * (addr % 4));
        if (f3[1:0] == 2'd0) begin
            v = sh & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'd1) begin
            v = sh & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int rdy_dly, input int rsp_dly);
        chk("req_ready_before", req_ready, 1);
        req_valid = 1; req_is_load = ld; req_is_store = st;
        req_funct3 = f3; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 0; req_is_load = 0; req_is_store = 0;
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        if (ld == st) begin
            chk("noop_fault", fault, 0);
            chk("noop_busy", busy, 0);
            chk("noop_memvalid", mem_req_valid, 0);
            chk("noop_ready", req_ready, 1);
            return;
        end
        if (!model_legal(ld, f3, addr)) begin
            chk("illegal_fault", fault, 1);
            chk("illegal_memvalid", mem_req_valid, 0);
            chk("illegal_ready", req_ready, 1);
            chk("illegal_busy", busy, 0);
            step();
            chk("illegal_fault_pulse", fault, 0);
            chk("illegal_memvalid2", mem_req_valid, 0);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("issue_valid", mem_req_valid, 1);
            chk("issue_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("issue_we", mem_we, st);
            chk("issue_strb", mem_wstrb, st ? model_strb(f3, addr) : 4'b0000);
            if (st) chk("issue_wdata", mem_wdata, model_wdata(f3, wd));
            chk("issue_busy", busy, 1);
            chk("issue_ready", req_ready, 0);
            if (i == rdy_dly) mem_req_ready = 1;
            step();
        end
        mem_req_ready = 0;
        for (int i = 0; i < rsp_dly; i++) begin
            chk("wait_memvalid", mem_req_valid, 0);
            chk("wait_busy", busy, 1);
            chk("wait_wbvalid", wb.valid, 0);
            step();
        end
        mem_rsp_valid = 1; mem_rdata = rd;
        step();
        mem_rsp_valid = 0; mem_rdata = $urandom;
        if (ld) last_wb = model_load(f3, addr, rd);
        chk("done_wbvalid", wb.valid, ld);
        chk("done_wbdata", wb.data, last_wb);
        chk("done_ready", req_ready, 0);
        chk("done_busy", busy, 1);
        chk("done_fault", fault, 0);
        step();
        chk("after_wbvalid", wb.valid, 0);
        chk("after_wbdata_hold", wb.data, last_wb);
        chk("after_busy", busy, 0);
        chk("after_ready", req_ready, 1);
    endtask

    initial begin
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] addr;

        rst = 1; req_valid = 0; req_is_load = 0; req_is_store = 0;
        req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_memvalid", mem_req_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_strb", mem_wstrb, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wb", wb, 0);
        chk("rst_fault", fault, 0);
        rst = 0;
        step();
        mem_rsp_valid = 0;
        chk("stray_rsp_idle_wb", wb.valid, 0);

        // Directed cases
        txn(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
        txn(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
        txn(0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 0, 0);
        txn(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
        txn(0, 1, 3'b001, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
        txn(0, 1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
        txn(1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'hA5A5_0000, 5, 1);
        txn(1, 1, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 0, 0);
        txn(0, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 0, 0);
        txn(0, 1, 3'b000, 32'h0000_6001, 32'h1234_56C3, 32'h0, 1, 2);
        txn(1, 0, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 0, 2);

        // Response timeout
        req_valid = 1; req_is_load = 1; req_is_store = 0;
        req_funct3 = 3'b010; req_addr = 32'h0000_7000;
        step();
        req_valid = 0; req_is_load = 0;
        chk("tmo_issue", mem_req_valid, 1);
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        for (int i = 0; i < int'(TMO); i++) begin
            chk("tmo_wait_fault", fault, 0);
            chk("tmo_wait_busy", busy, 1);
            step();
        end
        chk("tmo_fault", fault, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_ready", req_ready, 1);
        chk("tmo_wbvalid", wb.valid, 0);
        mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_rsp_valid = 0;
        chk("late_rsp_fault", fault, 0);
        chk("late_rsp_wbvalid", wb.valid, 0);
        chk("late_rsp_wbdata", wb.data, last_wb);
        chk("late_rsp_busy", busy, 0);

        // Reset in the middle of WAIT
        req_valid = 1; req_is_load = 1; req_funct3 = 3'b010; req_addr = 32'h0000_0010;
        step();
        req_valid = 0; req_is_load = 0;
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        step();
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        #1;
        last_wb = 32'h0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_memvalid", mem_req_valid, 0);
        chk("midrst_wb", wb, 0);
        chk("midrst_fault", fault, 0);
        chk("midrst_addr", mem_addr, 0);
        step();
        rst = 0;
        mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 0;
        chk("postrst_rsp_wb", wb, 0);
        chk("postrst_rsp_busy", busy, 0);
        chk("postrst_rsp_fault", fault, 0);
        txn(1, 0, 3'b010, 32'h0000_0000, 32'h0, 32'h1357_9BDF, 0, 0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                ld = 1'($urandom); st = ld;
            end else begin
                ld = 1'($urandom); st = !ld;
            end
            f3 = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            txn(ld, st, f3, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory-access stage between execute and write-back of the core.
- Accepts one load or store request from execute, at most one transaction in flight.
- Drives a valid/ready data-memory port with a word-aligned address and byte strobes.
- Sign- or zero-extends load data and presents it to write-back as a write_back_t (data, valid).

Parameters:
RSP_TIMEOUT, 255, max cycles spent in WAIT for mem_rsp_valid before a fault; 0 disables the timeout.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  execute presents a request
req_ready  output  1  unit can accept a request (IDLE only)
req_is_load  input  1  request is a load
req_is_store  input  1  request is a store
req_funct3  input  3  load_store_funct3_t encoding
req_addr  input  32  byte address (ALU result)
req_wdata  input  32  store data (rs2)
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_addr  output  32  word address, {req_addr[31:2],2'b00}
mem_we  output  1  1 = store
mem_wstrb  output  4  byte enables (0000 for loads)
mem_wdata  output  32  lane-replicated store data
mem_rsp_valid  input  1  memory response/ack, single-cycle pulse
mem_rdata  input  32  read data, valid with mem_rsp_valid
wb  output  33  write_back_t: data[32:1], valid[0]
busy  output  1  state != IDLE
fault  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset (async) -> IDLE; every output 0 except req_ready = 1; timeout counter = 0.
- IDLE: req_ready = 1. Handshake = req_valid & req_ready.
  - Exactly one of is_load/is_store set: latch addr, funct3, wdata and type.
  - Both or neither set: consume as a no-op; no fault, no wb, stay in IDLE.
- Legality check at the handshake:
  - Loads: funct3 in {000,001,010,100,101}. Stores: funct3 in {000,001,010}.
  - Halfword requires addr[0] = 0. Word requires addr[1:0] = 0.
  - Illegal or misaligned: fault = 1 in the next cycle, no memory access, stay in IDLE.
  - Legal: go to ISSUE.
- ISSUE: mem_req_valid = 1. mem_addr, mem_we, mem_wstrb and mem_wdata are registered and stable until mem_req_ready. On mem_req_ready -> WAIT and clear the timeout counter.
- Store strobes and data:
  - Byte: strb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: strb = 0011 << (2*addr[1]); wdata = {2{wdata[15:0]}}.
  - Word: strb = 1111; wdata unchanged.
- WAIT: counter increments each cycle. mem_rsp_valid is legal no earlier than the cycle after acceptance.
  - On mem_rsp_valid with a load: register the extracted data into wb.data and go to DONE.
  - On mem_rsp_valid with a store: go to DONE with wb.data unchanged.
  - If RSP_TIMEOUT != 0 and the counter reaches RSP_TIMEOUT without a response: fault pulse, -> IDLE, no wb.
- Load extraction:
  - Byte: lane = addr[1:0], byte = mem_rdata[8*lane +: 8]. Funct3 000 sign-extends, 100 zero-extends.
  - Half: lane = addr[1], half = mem_rdata[16*lane +: 16]. Funct3 001 sign-extends, 101 zero-extends.
  - Word: data passed unchanged.
- DONE: wb.valid = 1 for exactly this cycle, loads only (stores keep wb.valid = 0). req_ready = 0. -> IDLE.
- Minimum latency: handshake at cycle 0, ISSUE at 1, memory accepts at 1, response at 2, wb.valid at 3. Next request can be accepted at cycle 4.
- mem_rsp_valid in IDLE, ISSUE or DONE is ignored (covers stray responses after reset).
- wb.data holds its last value when wb.valid = 0.
- Reset mid-transaction aborts immediately: no wb, no fault, outputs cleared.

Test Plan:
- LB at 0x1003, mem_rdata = 0x80FF_1234, immediate ready/response -> mem_addr = 0x1000, wstrb = 0000; wb = {0xFFFF_FF80, valid} at cycle 3. Same access as LBU -> 0x0000_0080.
- SH at 0x2002, wdata = 0xDEAD_BEEF -> mem_we = 1, wstrb = 1100, mem_wdata = 0xBEEF_BEEF; ack causes no wb.valid; busy falls after DONE.
- LW at 0x3001 -> fault pulse 1 cycle, mem_req_valid never asserts, req_ready returns immediately. SH at 0x3001 -> fault. SB funct3 = 100 -> fault.
- mem_req_ready held low 5 cycles -> mem_req_valid and payload stable all 5 cycles. LHU at 0x4002, mem_rdata = 0xA5A5_0000 -> wb.data = 0x0000_A5A5.
- RSP_TIMEOUT = 4, no response -> fault after 4 WAIT cycles, return to IDLE. A late mem_rsp_valid is ignored and no wb is produced.
- rst asserted during WAIT -> outputs 0 and state IDLE at once. Response in the following cycle is ignored; the next LW at 0x0 completes normally.
